// File: rtl/pe_job_ctrl.sv
// Job sequencer for one PE: latches a job descriptor, walks the PE through its
// phase order, and gates the valid/ready handshakes of the phase in progress.
module pe_job_ctrl #(
    parameter int DATA_BITS   = 32,
    parameter int CONFIG_SIZE = 10,
    parameter int CNT_W       = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [CONFIG_SIZE-1:0] cfg_in,
    input  logic [CNT_W-1:0]       filt_num,
    input  logic [CNT_W-1:0]       ifmap_num,
    input  logic [CNT_W-1:0]       slide_num,
    input  logic [CNT_W-1:0]       out_num,
    output logic                   busy,
    output logic                   done,
    output logic                   pe_en,
    output logic [CONFIG_SIZE-1:0] pe_config,
    input  logic                   src_filter_valid,
    output logic                   src_filter_ready,
    output logic                   pe_filter_valid,
    input  logic                   pe_filter_ready,
    input  logic                   src_ifmap_valid,
    output logic                   src_ifmap_ready,
    output logic                   pe_ifmap_valid,
    input  logic                   pe_ifmap_ready,
    input  logic                   src_ipsum_valid,
    output logic                   src_ipsum_ready,
    output logic                   pe_ipsum_valid,
    input  logic                   pe_ipsum_ready,
    input  logic                   pe_opsum_valid,
    output logic                   pe_opsum_ready,
    output logic                   dst_opsum_valid,
    input  logic                   dst_opsum_ready
);

    // Data buses bypass this block; the width only matters at integration.
    if (DATA_BITS < 1) begin : g_bad_data_bits
    end

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CFG   = 3'd1,
        S_FILT  = 3'd2,
        S_IFMAP = 3'd3,
        S_IPSUM = 3'd4,
        S_OPSUM = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]       out_cnt_q, out_cnt_d;
    logic [CNT_W-1:0]       target_q, target_d;
    logic [CONFIG_SIZE-1:0] cfg_q, cfg_d;
    logic [CNT_W-1:0]       filt_q, filt_d;
    logic [CNT_W-1:0]       ifmap_q, ifmap_d;
    logic [CNT_W-1:0]       slide_q, slide_d;
    logic [CNT_W-1:0]       out_num_q, out_num_d;

    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] out_inc;
    logic             filt_beat, ifmap_beat, ipsum_beat, opsum_beat;

    assign cnt_inc = cnt_q + CNT_W'(1);
    assign out_inc = out_cnt_q + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            out_cnt_q <= '0;
            target_q  <= '0;
            cfg_q     <= '0;
            filt_q    <= '0;
            ifmap_q   <= '0;
            slide_q   <= '0;
            out_num_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            out_cnt_q <= out_cnt_d;
            target_q  <= target_d;
            cfg_q     <= cfg_d;
            filt_q    <= filt_d;
            ifmap_q   <= ifmap_d;
            slide_q   <= slide_d;
            out_num_q <= out_num_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        out_cnt_d = out_cnt_q;
        target_d  = target_q;
        cfg_d     = cfg_q;
        filt_d    = filt_q;
        ifmap_d   = ifmap_q;
        slide_d   = slide_q;
        out_num_d = out_num_q;
        unique case (state_q)
            S_IDLE: begin
                if (start && (out_num != '0)) begin
                    cfg_d     = cfg_in;
                    filt_d    = filt_num;
                    ifmap_d   = ifmap_num;
                    slide_d   = slide_num;
                    out_num_d = out_num;
                    out_cnt_d = '0;
                    state_d   = S_CFG;
                end
            end
            S_CFG: begin
                if (filt_q != '0) begin
                    state_d = S_FILT;
                end else if (ifmap_q != '0) begin
                    state_d  = S_IFMAP;
                    target_d = ifmap_q;
                end else begin
                    state_d = S_IPSUM;
                end
            end
            S_FILT: begin
                if (filt_beat) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == filt_q) begin
                        if (ifmap_q != '0) begin
                            state_d  = S_IFMAP;
                            target_d = ifmap_q;
                        end else begin
                            state_d = S_IPSUM;
                        end
                    end
                end
            end
            S_IFMAP: begin
                if (ifmap_beat) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == target_q) begin
                        state_d = S_IPSUM;
                    end
                end
            end
            S_IPSUM: begin
                if (ipsum_beat) begin
                    state_d = S_OPSUM;
                end
            end
            S_OPSUM: begin
                if (opsum_beat) begin
                    out_cnt_d = out_inc;
                    if (out_inc == out_num_q) begin
                        state_d = S_DONE;
                    end else if (slide_q != '0) begin
                        state_d  = S_IFMAP;
                        target_d = slide_q;
                    end else begin
                        state_d = S_IPSUM;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Every state starts counting its beats from zero.
        if (state_d != state_q) begin
            cnt_d = '0;
        end
    end

    always_comb begin
        busy      = (state_q != S_IDLE);
        done      = (state_q == S_DONE);
        pe_en     = (state_q != S_IDLE) && (state_q != S_DONE);
        pe_config = cfg_q;

        pe_filter_valid  = src_filter_valid && (state_q == S_FILT);
        src_filter_ready = pe_filter_ready  && (state_q == S_FILT);
        pe_ifmap_valid   = src_ifmap_valid  && (state_q == S_IFMAP);
        src_ifmap_ready  = pe_ifmap_ready   && (state_q == S_IFMAP);
        pe_ipsum_valid   = src_ipsum_valid  && (state_q == S_IPSUM);
        src_ipsum_ready  = pe_ipsum_ready   && (state_q == S_IPSUM);
        dst_opsum_valid  = pe_opsum_valid   && (state_q == S_OPSUM);
        pe_opsum_ready   = dst_opsum_ready  && (state_q == S_OPSUM);

        filt_beat  = pe_filter_valid && src_filter_ready;
        ifmap_beat = pe_ifmap_valid  && src_ifmap_ready;
        ipsum_beat = pe_ipsum_valid  && src_ipsum_ready;
        opsum_beat = dst_opsum_valid && pe_opsum_ready;
    end

endmodule

// File: tb/tb_pe_job_ctrl.sv
// Bench for pe_job_ctrl: a phase-queue model predicts every output each cycle;
// directed jobs pin done timing and beat totals with hand-computed numbers.
module tb_pe_job_ctrl;
    localparam int CS = 10;
    localparam int CW = 8;
    localparam int P_IDLE = 0, P_CFG = 1, P_FILT = 2, P_IFMAP = 3,
                   P_IPSUM = 4, P_OPSUM = 5, P_DONE = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [CS-1:0] cfg_in = '0;
    logic [CW-1:0] filt_num = '0, ifmap_num = '0, slide_num = '0, out_num = '0;
    logic          busy, done, pe_en;
    logic [CS-1:0] pe_config;
    logic src_filter_valid = 1'b1, pe_filter_ready = 1'b1;
    logic src_ifmap_valid = 1'b1, pe_ifmap_ready = 1'b1;
    logic src_ipsum_valid = 1'b1, pe_ipsum_ready = 1'b1;
    logic pe_opsum_valid = 1'b1, dst_opsum_ready = 1'b1;
    logic src_filter_ready, pe_filter_valid, src_ifmap_ready, pe_ifmap_valid;
    logic src_ipsum_ready, pe_ipsum_valid, pe_opsum_ready, dst_opsum_valid;

    pe_job_ctrl #(.DATA_BITS(32), .CONFIG_SIZE(CS), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_in(cfg_in),
        .filt_num(filt_num), .ifmap_num(ifmap_num), .slide_num(slide_num), .out_num(out_num),
        .busy(busy), .done(done), .pe_en(pe_en), .pe_config(pe_config),
        .src_filter_valid(src_filter_valid), .src_filter_ready(src_filter_ready),
        .pe_filter_valid(pe_filter_valid), .pe_filter_ready(pe_filter_ready),
        .src_ifmap_valid(src_ifmap_valid), .src_ifmap_ready(src_ifmap_ready),
        .pe_ifmap_valid(pe_ifmap_valid), .pe_ifmap_ready(pe_ifmap_ready),
        .src_ipsum_valid(src_ipsum_valid), .src_ipsum_ready(src_ipsum_ready),
        .pe_ipsum_valid(pe_ipsum_valid), .pe_ipsum_ready(pe_ipsum_ready),
        .pe_opsum_valid(pe_opsum_valid), .pe_opsum_ready(pe_opsum_ready),
        .dst_opsum_valid(dst_opsum_valid), .dst_opsum_ready(dst_opsum_ready)
    );

    always #5 clk = ~clk;

    // Model: a job is a list of phases, each needing a number of beats.
    int            ph_q[$];
    int            rem_q[$];
    logic [CS-1:0] m_cfg = '0;
    int            cyc = 0;

    function automatic int head();
        return (ph_q.size() != 0) ? ph_q[0] : P_IDLE;
    endfunction

    function automatic void push(int p, int n);
        if (n > 0) begin
            ph_q.push_back(p);
            rem_q.push_back(n);
        end
    endfunction

    function automatic void build(int f, int i, int s, int o);
        push(P_CFG, 1);
        push(P_FILT, f);
        push(P_IFMAP, i);
        push(P_IPSUM, 1);
        push(P_OPSUM, 1);
        for (int k = 1; k < o; k++) begin
            push(P_IFMAP, s);
            push(P_IPSUM, 1);
            push(P_OPSUM, 1);
        end
        push(P_DONE, 1);
    endfunction

    always @(posedge clk) begin
        bit beat;
        cyc = cyc + 1;
        if (rst) begin
            ph_q.delete();
            rem_q.delete();
            m_cfg = '0;
        end else if (ph_q.size() == 0) begin
            if (start && (out_num != 0)) begin
                m_cfg = cfg_in;
                build(int'(filt_num), int'(ifmap_num), int'(slide_num), int'(out_num));
            end
        end else begin
            case (ph_q[0])
                P_FILT:  beat = src_filter_valid && pe_filter_ready;
                P_IFMAP: beat = src_ifmap_valid && pe_ifmap_ready;
                P_IPSUM: beat = src_ipsum_valid && pe_ipsum_ready;
                P_OPSUM: beat = pe_opsum_valid && dst_opsum_ready;
                default: beat = 1'b1;
            endcase
            if (beat) begin
                rem_q[0] = rem_q[0] - 1;
                if (rem_q[0] == 0) begin
                    void'(ph_q.pop_front());
                    void'(rem_q.pop_front());
                end
            end
        end
    end

    int checks = 0, failures = 0;
    bit chk_en = 1'b0;
    bit stall_mode = 1'b0;
    int opsum_wait = 0;
    int n_filt = 0, n_ifmap = 0, n_ipsum = 0, n_opsum = 0, n_done = 0, done_cyc = 0;

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // One cycle: compare against the model at negedge, then move past the next
    // posedge and update the stall pattern.
    task automatic tick();
        logic [20:0] exp_v, act_v;
        int h;
        @(negedge clk);
        if (chk_en) begin
            h = head();
            exp_v = {h != P_IDLE, h == P_DONE, (h != P_IDLE) && (h != P_DONE), m_cfg,
                     src_filter_valid && (h == P_FILT), pe_filter_ready && (h == P_FILT),
                     src_ifmap_valid && (h == P_IFMAP), pe_ifmap_ready && (h == P_IFMAP),
                     src_ipsum_valid && (h == P_IPSUM), pe_ipsum_ready && (h == P_IPSUM),
                     pe_opsum_valid && (h == P_OPSUM), dst_opsum_ready && (h == P_OPSUM)};
            act_v = {busy, done, pe_en, pe_config,
                     pe_filter_valid, src_filter_ready, pe_ifmap_valid, src_ifmap_ready,
                     pe_ipsum_valid, src_ipsum_ready, dst_opsum_valid, pe_opsum_ready};
            checks++;
            if (act_v !== exp_v) begin
                failures++;
                $display("FAIL outputs cyc=%0d phase=%0d got=%b expected=%b", cyc, h, act_v, exp_v);
            end
            if (pe_filter_valid && src_filter_ready) n_filt++;
            if (pe_ifmap_valid && src_ifmap_ready) n_ifmap++;
            if (pe_ipsum_valid && src_ipsum_ready) n_ipsum++;
            if (dst_opsum_valid && pe_opsum_ready) n_opsum++;
            if (done) begin
                n_done++;
                done_cyc = cyc;
            end
        end
        @(posedge clk);
        #1;
        if (stall_mode) begin
            src_ifmap_valid = (cyc % 2) == 1;
            if (head() == P_OPSUM && opsum_wait < 4) begin
                dst_opsum_ready = 1'b0;
                opsum_wait++;
            end else begin
                dst_opsum_ready = 1'b1;
                if (head() != P_OPSUM) opsum_wait = 0;
            end
        end else begin
            src_ifmap_valid = 1'b1;
            dst_opsum_ready = 1'b1;
        end
    endtask

    // exp_done < 0: only require the job to take longer than the unstalled 13.
    task automatic job(string name, int f, int i, int s, int o, logic [CS-1:0] cfg,
                       bit mid, int exp_done, int ef, int ei, int ep, int eo);
        int b_f, b_i, b_p, b_o, d0, sc, rel;
        b_f = n_filt; b_i = n_ifmap; b_p = n_ipsum; b_o = n_opsum; d0 = n_done;
        cfg_in = cfg; filt_num = CW'(f); ifmap_num = CW'(i); slide_num = CW'(s); out_num = CW'(o);
        start = 1'b1;
        sc = cyc;
        tick();
        start = 1'b0;
        cfg_in = ~cfg; filt_num = 8'hAA; ifmap_num = 8'h55; slide_num = 8'h33; out_num = 8'h77;
        for (int k = 0; k < 300 && n_done == d0; k++) begin
            if (mid && cyc == sc + 5) begin
                start = 1'b1; filt_num = 8'd7; out_num = 8'd1;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
        check({name, "_done_seen"}, n_done - d0, 1);
        rel = done_cyc - sc;
        if (exp_done >= 0) check({name, "_done_cycle"}, rel, exp_done);
        else check({name, "_done_late"}, int'(rel > 13), 1);
        check({name, "_busy_after_done"}, int'(busy), 0);
        check({name, "_filt_beats"}, n_filt - b_f, ef);
        check({name, "_ifmap_beats"}, n_ifmap - b_i, ei);
        check({name, "_ipsum_beats"}, n_ipsum - b_p, ep);
        check({name, "_opsum_beats"}, n_opsum - b_o, eo);
        $display("job %s: done at start+%0d, beats f=%0d i=%0d p=%0d o=%0d", name, rel,
                 n_filt - b_f, n_ifmap - b_i, n_ipsum - b_p, n_opsum - b_o);
    endtask

    initial begin
        int d0;
        tick();
        chk_en = 1'b1;
        tick();
        rst = 1'b0;
        check("reset_busy", int'(busy), 0);
        check("reset_pe_config", int'(pe_config), 0);
        check("idle_gated_outputs", int'({pe_filter_valid, src_filter_ready, pe_ifmap_valid,
              src_ifmap_ready, pe_ipsum_valid, src_ipsum_ready, dst_opsum_valid, pe_opsum_ready}), 0);
        tick();

        job("nominal", 3, 3, 1, 2, 10'h2A5, 1'b0, 13, 3, 4, 2, 2);
        tick();
        stall_mode = 1'b1;
        job("stall", 3, 3, 1, 2, 10'h13C, 1'b0, -1, 3, 4, 2, 2);
        stall_mode = 1'b0;
        tick();
        job("zero", 0, 0, 0, 3, 10'h001, 1'b0, 8, 0, 0, 3, 3);
        tick();

        // out_num==0 start must be ignored.
        filt_num = 8'd3; ifmap_num = 8'd3; out_num = 8'd0; start = 1'b1;
        tick();
        start = 1'b0;
        check("zero_out_start_busy", int'(busy), 0);
        tick();
        check("zero_out_start_busy_later", int'(busy), 0);

        job("midstart", 3, 3, 1, 2, 10'h3F0, 1'b1, 13, 3, 4, 2, 2);
        tick();

        // Reset during FILT after one beat.
        d0 = n_done;
        cfg_in = 10'h155; filt_num = 8'd3; ifmap_num = 8'd3; slide_num = 8'd1; out_num = 8'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_busy", int'(busy), 0);
        check("rst_mid_pe_en", int'(pe_en), 0);
        check("rst_mid_pe_config", int'(pe_config), 0);
        check("rst_mid_filter_valid", int'(pe_filter_valid), 0);
        tick();
        tick();
        check("rst_mid_no_done", n_done - d0, 0);
        job("after_reset", 3, 3, 1, 2, 10'h0F3, 1'b0, 13, 3, 4, 2, 2);
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pe_job_ctrl.md
# pe_job_ctrl

Sequencer for one PE. It accepts a job descriptor (PE configuration word plus beat counts), then enforces the PE's phase order: configure, load filter, load ifmap, then one ipsum and one opsum per output. Between outputs it loads a sliding ifmap window. It gates the valid/ready handshakes between the upstream buffers (GLB/NoC side) and the PE; data buses bypass the block. One instance sits beside each PE or PE column in the PE array.

## Interface
- DATA_BITS, 32, PE data width; unused internally, kept for integration symmetry.
- CONFIG_SIZE, 10, width of the PE configuration word.
- CNT_W, 8, width of all beat counters and count inputs.

- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  job request; sampled only in IDLE.
- cfg_in  in  CONFIG_SIZE  PE configuration; latched on accepted start.
- filt_num  in  CNT_W  filter beats; latched on start.
- ifmap_num  in  CNT_W  ifmap beats before the first output; latched on start.
- slide_num  in  CNT_W  ifmap beats before each later output; latched on start.
- out_num  in  CNT_W  number of opsums in the job; latched on start.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse in DONE.
- pe_en  out  1  PE enable.
- pe_config  out  CONFIG_SIZE  latched cfg_in.
- src_filter_valid / src_filter_ready  in / out  1  upstream filter handshake.
- pe_filter_valid / pe_filter_ready  out / in  1  PE filter handshake.
- src_ifmap_valid / src_ifmap_ready  in / out  1  upstream ifmap handshake.
- pe_ifmap_valid / pe_ifmap_ready  out / in  1  PE ifmap handshake.
- src_ipsum_valid / src_ipsum_ready  in / out  1  upstream ipsum handshake.
- pe_ipsum_valid / pe_ipsum_ready  out / in  1  PE ipsum handshake.
- pe_opsum_valid / pe_opsum_ready  in / out  1  PE opsum handshake.
- dst_opsum_valid / dst_opsum_ready  out / in  1  downstream opsum handshake.

## Operation
- States: IDLE, CFG, FILT, IFMAP, IPSUM, OPSUM, DONE.
- Gating, combinational, for each channel X:
  - pe_X_valid = src_X_valid && (state==X); src_X_ready = pe_X_ready && (state==X).
  - Opsum: dst_opsum_valid = pe_opsum_valid && (state==OPSUM); pe_opsum_ready = dst_opsum_ready && (state==OPSUM).
- A beat is a cycle where the gated valid and the gated ready are both high.
- IDLE: all gated outputs 0.
  - If start && out_num!=0: latch the descriptor, clear out_cnt, go to CFG.
  - If start && out_num==0: the start is ignored.
- CFG: lasts exactly 1 cycle, with pe_en=1 and pe_config valid.
  - Next state is FILT if filt_num!=0; otherwise IFMAP with target=ifmap_num.
- FILT: count filter beats. On the beat that makes the count equal filt_num, go to IFMAP with target=ifmap_num.
- IFMAP: count ifmap beats. When the count reaches target, go to IPSUM.
  - If target==0 on entry, the state is bypassed: the previous state transitions directly to IPSUM.
- IPSUM: one beat, then go to OPSUM.
- OPSUM: one beat, then out_cnt+1.
  - If out_cnt+1==out_num, go to DONE.
  - Otherwise go to IFMAP with target=slide_num; if slide_num==0, go to IPSUM.
- DONE: done=1 and pe_en=0 for 1 cycle, then IDLE.
- pe_en=1 in CFG, FILT, IFMAP, IPSUM and OPSUM; pe_en=0 in IDLE and DONE.
- Beat counters are CNT_W bits and reset to 0 on every state entry. They never wrap because the terminal compare is equality.
- start asserted while busy is ignored. Descriptor inputs may change after the accepting cycle.

## Timing
- Reset values: state=IDLE; busy=0, done=0, pe_en=0, pe_config=0; all gated valid/ready outputs 0; all counters 0.
- Reset mid-job: on the next cycle the block is in IDLE with all outputs at their reset values. No done pulse is issued.
- start sampled in cycle t puts the block in CFG at cycle t+1; busy=1 from t+1.
- The beat count of each state is unaffected by stalls (any valid or ready low); the state simply holds.
- Minimum job length with no stalls:
  - From the CFG cycle to the DONE cycle inclusive: 1 + filt_num + ifmap_num + 2*out_num + (out_num-1)*slide_num + 1 cycles.
- A new start is accepted in the cycle after DONE (IDLE), at the earliest.

## Test plan
- Nominal job: filt_num=3, ifmap_num=3, slide_num=1, out_num=2, all sources/sinks always valid/ready, start at cycle 0. Expected sequence:
  - CFG at cycle 1, FILT 2-4, IFMAP 5-7, IPSUM 8, OPSUM 9, IFMAP 10, IPSUM 11, OPSUM 12.
  - done pulse at cycle 13; busy=0 at cycle 14.
  - Exactly 3 filter, 4 ifmap, 2 ipsum and 2 opsum beats.
- Stalls: same job with src_ifmap_valid toggled every other cycle and dst_opsum_ready low for 4 cycles in each OPSUM.
  - Beat counts are unchanged; the state holds during stalls.
  - No gated valid/ready is asserted outside its phase.
- Zero counts: filt_num=0, ifmap_num=0, slide_num=0, out_num=3.
  - Sequence CFG, IPSUM, OPSUM ×3, DONE: done at cycle 8 after start at cycle 0.
- Ignored starts: start with out_num=0 leaves busy=0. start pulsed mid-job does not restart the job or change the latched counts.
- Reset mid-job: assert rst during FILT after 1 beat.
  - Next cycle: all outputs 0 and no done pulse.
  - A new job then completes normally.
- Gating isolation: hold all src/pe valids and readys at 1 in IDLE and DONE. All gated outputs stay 0.
